smul_seq: RTL



---
 rtl/smul_pkg.sv | 8 +
 rtl/smul_seq.sv | 98 +++++++++
 2 files changed

// File: rtl/smul_pkg.sv
// Shared types and defaults for the shift-add unsigned multiplier coprocessor.
package smul_pkg;

    typedef enum logic {IDLE, BUSY} smul_st_t;

    localparam int SMUL_WID = 16;

endpackage

// File: rtl/smul_seq.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per clock, WID-cycle latency.
// crdy gates the program counter's wait; prod/pzro hold the last result until the next completes.
module smul_seq
    import smul_pkg::*;
#(
    parameter int WID = SMUL_WID
) (
    input  logic             ck,
    input  logic             rb,
    input  logic             cstr,
    input  logic [WID-1:0]   ain,
    input  logic [WID-1:0]   bin,
    output logic             crdy,
    output logic [2*WID-1:0] prod,
    output logic             pzro
);

    localparam int CW = $clog2(WID);

    smul_st_t         state_q, state_d;
    logic [WID-1:0]   mcnd_q, mcnd_d;
    logic [WID-1:0]   acc_q, acc_d;
    logic [WID-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             crdy_q, crdy_d;
    logic [2*WID-1:0] prod_q, prod_d;
    logic             pzro_q, pzro_d;

    // Carry bit of the partial sum is kept and shifted into the accumulator MSB.
    logic [WID:0]     sum;
    logic [2*WID-1:0] shf;

    always_comb begin
        state_d = state_q;
        mcnd_d  = mcnd_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        crdy_d  = crdy_q;
        prod_d  = prod_q;
        pzro_d  = pzro_q;

        sum = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcnd_q} : {(WID+1){1'b0}});
        shf = {sum, mplr_q[WID-1:1]};

        case (state_q)
            IDLE: begin
                if (cstr) begin
                    mcnd_d  = ain;
                    acc_d   = '0;
                    mplr_d  = bin;
                    cnt_d   = CW'(WID - 1);
                    state_d = BUSY;
                    crdy_d  = 1'b0;
                end
            end
            BUSY: begin
                acc_d  = shf[2*WID-1:WID];
                mplr_d = shf[WID-1:0];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    prod_d  = shf;
                    pzro_d  = (shf == '0);
                    crdy_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rb) begin
        if (!rb) begin
            state_q <= IDLE;
            mcnd_q  <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            crdy_q  <= 1'b1;
            prod_q  <= '0;
            pzro_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            mcnd_q  <= mcnd_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            crdy_q  <= crdy_d;
            prod_q  <= prod_d;
            pzro_q  <= pzro_d;
        end
    end

    assign crdy = crdy_q;
    assign prod = prod_q;
    assign pzro = pzro_q;

endmodule
